unpooling_layer: RTL
====================

UNPOOLING_LAYER -- requirements
Module: unpooling_layer

Interface
REQ-001 Parameter DATA_WIDTH, default 8, bit width of one feature element.
REQ-002 Parameter IN_WIDTH, default 16, pooled input map columns.
REQ-003 Parameter IN_HEIGHT, default 16, pooled input map rows.
REQ-004 Parameter NUM_KERNELS, default 3, number of feature maps per frame.
REQ-005 Parameter POOL_SIZE, default 2, upsampling factor in each dimension; OUT_WIDTH=IN_WIDTH*POOL_SIZE, OUT_HEIGHT=IN_HEIGHT*POOL_SIZE.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 unpool_type  input  1  0=nearest replicate, 1=zero-insert; sampled on accepted valid_in.
REQ-009 valid_in  input  1  start pulse; captures input_value.
REQ-010 input_value  input  DATA_WIDTH*NUM_KERNELS*IN_WIDTH*IN_HEIGHT  flattened pooled maps; element (k,r,c) at index k*IN_HEIGHT*IN_WIDTH+r*IN_WIDTH+c, LSB first.
REQ-011 busy  output  1  high from accept until all_done cycle inclusive.
REQ-012 valid_out  output  1  one-cycle pulse per completed kernel.
REQ-013 num_kernels_complete  output  NUM_KERNELS  count of kernels finished in current frame.
REQ-014 output_value  output  DATA_WIDTH*NUM_KERNELS*OUT_WIDTH*OUT_HEIGHT  flattened upsampled maps; element (k,R,C) at index k*OUT_HEIGHT*OUT_WIDTH+R*OUT_WIDTH+C.
REQ-015 all_done  output  1  one-cycle pulse when last kernel completes.

Function
REQ-016 FSM states IDLE, RUN, KDONE, DONE; IDLE->RUN on valid_in, RUN->KDONE after last input element of a kernel, KDONE->RUN if kernels remain else DONE, DONE->IDLE unconditionally.
REQ-017 On accept, input_value and unpool_type register internally; later input changes have no effect on the frame.
REQ-018 RUN processes one input element per cycle in row-major order, writing all POOL_SIZE*POOL_SIZE output elements of its block that cycle.
REQ-019 Replicate: out(k,R,C)=in(k,R/POOL_SIZE,C/POOL_SIZE), integer division.
REQ-020 Zero-insert: out(k,R,C)=in(k,R/POOL_SIZE,C/POOL_SIZE) when R%POOL_SIZE==0 and C%POOL_SIZE==0, else zero.
REQ-021 No arithmetic on element values; output elements are bit-exact copies or zero.
REQ-022 KDONE: valid_out=1 one cycle, num_kernels_complete increments by 1.
REQ-023 DONE: all_done=1 one cycle; busy deasserts next cycle.
REQ-024 Latency: first valid_out IN_WIDTH*IN_HEIGHT+1 cycles after accept edge; all_done NUM_KERNELS*(IN_WIDTH*IN_HEIGHT+1)+1 cycles after accept.
REQ-025 valid_in while busy is ignored; frame continues unaffected.
REQ-026 valid_in in the DONE cycle is ignored; valid_in the cycle after all_done is accepted.
REQ-027 output_value holds the last frame result until overwritten element-by-element by the next frame.
REQ-028 num_kernels_complete clears to 0 on accept of a new frame and otherwise holds NUM_KERNELS after completion.

Reset
REQ-029 rst low at a clock edge forces IDLE, busy=0, valid_out=0, all_done=0, num_kernels_complete=0, output_value=0, internal counters and captured data =0.
REQ-030 Reset mid-frame aborts the frame with no valid_out/all_done; valid_in while rst low is ignored.

Configuration
REQ-031 Macro UNPOOL_ZERO_INSERT_EN defined: both modes per REQ-019/020.
REQ-032 Macro UNPOOL_ZERO_INSERT_EN undefined: unpool_type ignored, replicate only, zero-insert logic absent; timing unchanged.

Verification
REQ-033 IN 2x2, NUM_KERNELS=1, POOL_SIZE=2, in={1,2,3,4}, type 0 -> output rows {1,1,2,2},{1,1,2,2},{3,3,4,4},{3,3,4,4}; valid_out at cycle 5, all_done at cycle 6 after accept.
REQ-034 Same input, type 1, macro defined -> rows {1,0,2,0},{0,0,0,0},{3,0,4,0},{0,0,0,0}; macro undefined -> REQ-033 result.
REQ-035 Defaults, kernels filled 0xA0/0xB0/0xC0 -> three valid_out pulses 257 cycles apart, num_kernels_complete 1,2,3, each 32x32 map constant per kernel, all_done once.
REQ-036 valid_in repulsed with different data mid-frame -> output matches first frame only, timing unchanged.
REQ-037 rst low during kernel 2 -> all outputs 0 next cycle, no all_done; new valid_in after release completes full frame correctly.
REQ-038 Back-to-back frames, valid_in the cycle after all_done -> second frame accepted, num_kernels_complete restarts at 0.

Source files
------------

// File: rtl/unpooling_layer_if.sv
// unpooling_layer_if: frame handshake and data bus of the unpooling layer.
// master = frame source / result consumer, slave = unpooling_layer.
interface unpooling_layer_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int IN_WIDTH    = 16,
   parameter int IN_HEIGHT   = 16,
   parameter int NUM_KERNELS = 3,
   parameter int POOL_SIZE   = 2
);
   localparam int IN_BITS  = DATA_WIDTH * NUM_KERNELS * IN_WIDTH * IN_HEIGHT;
   localparam int OUT_BITS = IN_BITS * POOL_SIZE * POOL_SIZE;

   logic                   unpool_type;
   logic                   valid_in;
   logic [IN_BITS-1:0]     input_value;
   logic                   busy;
   logic                   valid_out;
   logic [NUM_KERNELS-1:0] num_kernels_complete;
   logic [OUT_BITS-1:0]    output_value;
   logic                   all_done;

   modport master (
      output unpool_type, valid_in, input_value,
      input  busy, valid_out, num_kernels_complete, output_value, all_done
   );

   modport slave (
      input  unpool_type, valid_in, input_value,
      output busy, valid_out, num_kernels_complete, output_value, all_done
   );
endinterface

// File: rtl/unpooling_layer.sv
// unpooling_layer: upsamples NUM_KERNELS pooled maps by POOL_SIZE in each
// dimension, one input element (one POOL_SIZE x POOL_SIZE output block) per
// cycle. Nearest-neighbour replicate is always available; zero-insert mode
// (unpool_type=1) exists only when the macro UNPOOL_ZERO_INSERT_EN is defined.
module unpooling_layer #(
   parameter int DATA_WIDTH  = 8,
   parameter int IN_WIDTH    = 16,
   parameter int IN_HEIGHT   = 16,
   parameter int NUM_KERNELS = 3,
   parameter int POOL_SIZE   = 2
) (
   input  logic              clk,
   input  logic              rst,
   unpooling_layer_if.slave  bus
);
   localparam int OUT_WIDTH  = IN_WIDTH * POOL_SIZE;
   localparam int OUT_HEIGHT = IN_HEIGHT * POOL_SIZE;
   localparam int IN_BITS    = DATA_WIDTH * NUM_KERNELS * IN_WIDTH * IN_HEIGHT;
   localparam int OUT_BITS   = DATA_WIDTH * NUM_KERNELS * OUT_WIDTH * OUT_HEIGHT;
   localparam int CW         = $clog2(IN_WIDTH + 1);
   localparam int RW         = $clog2(IN_HEIGHT + 1);
   localparam int KW         = $clog2(NUM_KERNELS + 1);

   typedef enum logic [1:0] {IDLE, RUN, KDONE, DONE} state_t;

   state_t                 state;
   logic [CW-1:0]          c_cnt;
   logic [RW-1:0]          r_cnt;
   logic [KW-1:0]          k_cnt;
   logic [IN_BITS-1:0]     in_cap;
   logic [OUT_BITS-1:0]    out_map;
   logic                   busy_r;
   logic                   valid_out_r;
   logic                   all_done_r;
   logic [NUM_KERNELS-1:0] nkc_r;
   logic [DATA_WIDTH-1:0]  cur_elem;
`ifdef UNPOOL_ZERO_INSERT_EN
   logic                   zi_cap;
`endif

   // Bit offset of input element (k,r,c) in the flattened input vector.
   function automatic int in_base(int k, int r, int c);
      return ((k * IN_HEIGHT + r) * IN_WIDTH + c) * DATA_WIDTH;
   endfunction

   // Bit offset of output element (k,R,C) in the flattened output vector.
   function automatic int out_base(int k, int r, int c);
      return ((k * OUT_HEIGHT + r) * OUT_WIDTH + c) * DATA_WIDTH;
   endfunction

`ifdef UNPOOL_ZERO_INSERT_EN
   // Zero-insert keeps only the top-left position of each output block.
   function automatic logic [DATA_WIDTH-1:0] pick(logic [DATA_WIDTH-1:0] v,
                                                  int dr, int dc, logic zi);
      return (zi && (dr != 0 || dc != 0)) ? '0 : v;
   endfunction
`endif

   // Select the captured input element addressed by the scan counters.
   always_comb begin
      cur_elem = in_cap[in_base(int'(k_cnt), int'(r_cnt), int'(c_cnt)) +: DATA_WIDTH];
   end

   // Frame control FSM with registered status outputs and output block writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         c_cnt       <= '0;
         r_cnt       <= '0;
         k_cnt       <= '0;
         in_cap      <= '0;
         out_map     <= '0;
         busy_r      <= 1'b0;
         valid_out_r <= 1'b0;
         all_done_r  <= 1'b0;
         nkc_r       <= '0;
`ifdef UNPOOL_ZERO_INSERT_EN
         zi_cap      <= 1'b0;
`endif
      end else begin
         valid_out_r <= 1'b0;
         all_done_r  <= 1'b0;
         case (state)
            IDLE: begin
               busy_r <= bus.valid_in;
               if (bus.valid_in) begin
                  state  <= RUN;
                  in_cap <= bus.input_value;
                  c_cnt  <= '0;
                  r_cnt  <= '0;
                  k_cnt  <= '0;
                  nkc_r  <= '0;
`ifdef UNPOOL_ZERO_INSERT_EN
                  zi_cap <= bus.unpool_type;
`endif
               end
            end
            RUN: begin
               for (int dr = 0; dr < POOL_SIZE; dr++) begin
                  for (int dc = 0; dc < POOL_SIZE; dc++) begin
`ifdef UNPOOL_ZERO_INSERT_EN
                     out_map[out_base(int'(k_cnt), int'(r_cnt) * POOL_SIZE + dr,
                                      int'(c_cnt) * POOL_SIZE + dc) +: DATA_WIDTH]
                        <= pick(cur_elem, dr, dc, zi_cap);
`else
                     out_map[out_base(int'(k_cnt), int'(r_cnt) * POOL_SIZE + dr,
                                      int'(c_cnt) * POOL_SIZE + dc) +: DATA_WIDTH]
                        <= cur_elem;
`endif
                  end
               end
               if (c_cnt == CW'(IN_WIDTH - 1)) begin
                  c_cnt <= '0;
                  if (r_cnt == RW'(IN_HEIGHT - 1)) begin
                     r_cnt <= '0;
                     state <= KDONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end else begin
                  c_cnt <= c_cnt + 1'b1;
               end
            end
            KDONE: begin
               valid_out_r <= 1'b1;
               nkc_r       <= nkc_r + 1'b1;
               if (k_cnt == KW'(NUM_KERNELS - 1)) begin
                  state <= DONE;
               end else begin
                  k_cnt <= k_cnt + 1'b1;
                  state <= RUN;
               end
            end
            DONE: begin
               all_done_r <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy                 = busy_r;
   assign bus.valid_out            = valid_out_r;
   assign bus.all_done             = all_done_r;
   assign bus.num_kernels_complete = nkc_r;
   assign bus.output_value         = out_map;
endmodule
